rdmx_xmit_arb: RTL and testbench



---
 rtl/rdmx_xmit_arb.sv | 206 ++++++++++++++++++++
 tb/tb_rdmx_xmit_arb.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rdmx_xmit_arb.sv
// Purpose : two-channel RDMX transmit scheduler; one header beat then that channel's data through TLAST, with a beat-count check.
// Latency : a channel becoming eligible in IDLE shows M_HDR_TVALID on the next cycle; data is a combinational pass-through.
// Backpressure: the header holds while M_HDR_TREADY=0; the granted channel's DATA_TREADY follows M_DATA_TREADY; the other channel is never readied.
//
// Ports:
//   clk, resetn                      clock, async active-low reset
//   Sn_PLEN_* (n=0,1)                packet byte-length FIFO head (pop on header accept)
//   Sn_ADDR_* (n=0,1)                target address + user data FIFO head (pop on header accept)
//   Sn_DATA_* (n=0,1)                packet data stream
//   M_HDR_*                          header beat {addr, user, byte length} to the packet builder
//   M_DATA_*                         forwarded data of the granted channel
//   GRANT / BUSY / LEN_ERR           current/last grant, HDR-or-DATA state, sticky beat-count mismatch
//
// Build option: define RDMX_XMIT_ARB_STRICT_PRIO_EN to make channel 0 win whenever it is eligible;
// without it the two channels alternate when both are eligible.

module rdmx_xmit_arb #(
    parameter int DW = 512,
    parameter int AW = 64,
    parameter int UW = 40
) (
    input  logic          clk,
    input  logic          resetn,

    input  logic [15:0]   S0_PLEN_TDATA,
    input  logic          S0_PLEN_TVALID,
    output logic          S0_PLEN_TREADY,
    input  logic [AW-1:0] S0_ADDR_TDATA,
    input  logic [UW-1:0] S0_ADDR_TUSER,
    input  logic          S0_ADDR_TVALID,
    output logic          S0_ADDR_TREADY,
    input  logic [DW-1:0] S0_DATA_TDATA,
    input  logic          S0_DATA_TLAST,
    input  logic          S0_DATA_TVALID,
    output logic          S0_DATA_TREADY,

    input  logic [15:0]   S1_PLEN_TDATA,
    input  logic          S1_PLEN_TVALID,
    output logic          S1_PLEN_TREADY,
    input  logic [AW-1:0] S1_ADDR_TDATA,
    input  logic [UW-1:0] S1_ADDR_TUSER,
    input  logic          S1_ADDR_TVALID,
    output logic          S1_ADDR_TREADY,
    input  logic [DW-1:0] S1_DATA_TDATA,
    input  logic          S1_DATA_TLAST,
    input  logic          S1_DATA_TVALID,
    output logic          S1_DATA_TREADY,

    output logic [AW-1:0] M_HDR_TDATA,
    output logic [UW-1:0] M_HDR_TUSER,
    output logic [15:0]   M_HDR_TLEN,
    output logic          M_HDR_TVALID,
    input  logic          M_HDR_TREADY,

    output logic [DW-1:0] M_DATA_TDATA,
    output logic          M_DATA_TLAST,
    output logic          M_DATA_TVALID,
    input  logic          M_DATA_TREADY,

    output logic          GRANT,
    output logic          BUSY,
    output logic          LEN_ERR
);

    localparam int BPB = DW / 8;
    localparam int SH  = $clog2(BPB);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        grant;
    logic        last_grant;
    logic [10:0] exp_beats;
    logic [10:0] beat_cnt;
    logic [10:0] beat_nxt;
    logic        len_err;

    logic [1:0]  elig;
    logic        pick;
    logic [15:0] pick_plen;
    logic [16:0] plen_round;
    logic [10:0] pick_beats_raw;
    logic [10:0] pick_beats;

    logic        cur_dvld;
    logic        cur_dlast;
    logic        data_fire;

    // A packet is schedulable only once both its length and address are queued;
    // length is written upstream after the last data beat, so data is complete.
    assign elig = {S1_PLEN_TVALID & S1_ADDR_TVALID, S0_PLEN_TVALID & S0_ADDR_TVALID};

`ifdef RDMX_XMIT_ARB_STRICT_PRIO_EN
    assign pick = ~elig[0];
`else
    // Both eligible: serve the channel that did not go last.
    assign pick = (elig == 2'b11) ? ~last_grant : elig[1];
`endif

    // Expected beats = max(1, ceil(len / bytes_per_beat)); zero-length packets still carry one beat.
    assign pick_plen      = pick ? S1_PLEN_TDATA : S0_PLEN_TDATA;
    assign plen_round     = {1'b0, pick_plen} + 17'(BPB - 1);
    assign pick_beats_raw = 11'(plen_round >> SH);
    assign pick_beats     = (pick_beats_raw == 11'd0) ? 11'd1 : pick_beats_raw;

    assign cur_dvld  = grant ? S1_DATA_TVALID : S0_DATA_TVALID;
    assign cur_dlast = grant ? S1_DATA_TLAST  : S0_DATA_TLAST;
    assign data_fire = (state == ST_DATA) & cur_dvld & M_DATA_TREADY;
    assign beat_nxt  = beat_cnt + 11'd1;

    // Header fields come straight from the granted FIFO heads, which stay put until popped.
    assign M_HDR_TDATA  = grant ? S1_ADDR_TDATA : S0_ADDR_TDATA;
    assign M_HDR_TUSER  = grant ? S1_ADDR_TUSER : S0_ADDR_TUSER;
    assign M_HDR_TLEN   = grant ? S1_PLEN_TDATA : S0_PLEN_TDATA;
    assign M_DATA_TDATA = grant ? S1_DATA_TDATA : S0_DATA_TDATA;
    assign M_DATA_TLAST = (state == ST_DATA) & cur_dlast;

    assign GRANT   = grant;
    assign BUSY    = (state != ST_IDLE);
    assign LEN_ERR = len_err;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        M_HDR_TVALID   = 1'b0;
        M_DATA_TVALID  = 1'b0;
        S0_PLEN_TREADY = 1'b0;
        S0_ADDR_TREADY = 1'b0;
        S1_PLEN_TREADY = 1'b0;
        S1_ADDR_TREADY = 1'b0;
        S0_DATA_TREADY = 1'b0;
        S1_DATA_TREADY = 1'b0;
        case (state)
            ST_IDLE: begin
                if (elig != 2'b00) begin
                    state_nxt = ST_HDR;
                end
            end
            ST_HDR: begin
                M_HDR_TVALID = 1'b1;
                if (M_HDR_TREADY) begin
                    // Single-cycle pop of the granted length/address entries.
                    S0_PLEN_TREADY = ~grant;
                    S0_ADDR_TREADY = ~grant;
                    S1_PLEN_TREADY = grant;
                    S1_ADDR_TREADY = grant;
                    state_nxt      = ST_DATA;
                end
            end
            ST_DATA: begin
                M_DATA_TVALID  = cur_dvld;
                S0_DATA_TREADY = ~grant & M_DATA_TREADY;
                S1_DATA_TREADY = grant & M_DATA_TREADY;
                if (data_fire && cur_dlast) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            grant      <= 1'b0;
            last_grant <= 1'b1;
            exp_beats  <= 11'd0;
            beat_cnt   <= 11'd0;
            len_err    <= 1'b0;
        end else begin
            if ((state == ST_IDLE) && (elig != 2'b00)) begin
                grant     <= pick;
                exp_beats <= pick_beats;
            end
            if ((state == ST_HDR) && M_HDR_TREADY) begin
                beat_cnt <= 11'd0;
            end
            if (data_fire) begin
                beat_cnt <= beat_nxt;
                // Flag a short packet at its TLAST and a long one as soon as it passes the declared count.
                if ((cur_dlast && (beat_nxt != exp_beats)) ||
                    (!cur_dlast && (beat_nxt == exp_beats))) begin
                    len_err <= 1'b1;
                end
                if (cur_dlast) begin
                    last_grant <= grant;
                end
            end
        end
    end

endmodule

// File: tb/tb_rdmx_xmit_arb.sv
module tb_rdmx_xmit_arb;

    localparam int DW = 512;
    localparam int AW = 64;
    localparam int UW = 40;

    logic          clk;
    logic          resetn;
    logic [15:0]   S0_PLEN_TDATA, S1_PLEN_TDATA;
    logic          S0_PLEN_TVALID, S1_PLEN_TVALID;
    logic          S0_PLEN_TREADY, S1_PLEN_TREADY;
    logic [AW-1:0] S0_ADDR_TDATA, S1_ADDR_TDATA;
    logic [UW-1:0] S0_ADDR_TUSER, S1_ADDR_TUSER;
    logic          S0_ADDR_TVALID, S1_ADDR_TVALID;
    logic          S0_ADDR_TREADY, S1_ADDR_TREADY;
    logic [DW-1:0] S0_DATA_TDATA, S1_DATA_TDATA;
    logic          S0_DATA_TLAST, S1_DATA_TLAST;
    logic          S0_DATA_TVALID, S1_DATA_TVALID;
    logic          S0_DATA_TREADY, S1_DATA_TREADY;
    logic [AW-1:0] M_HDR_TDATA;
    logic [UW-1:0] M_HDR_TUSER;
    logic [15:0]   M_HDR_TLEN;
    logic          M_HDR_TVALID, M_HDR_TREADY;
    logic [DW-1:0] M_DATA_TDATA;
    logic          M_DATA_TLAST, M_DATA_TVALID, M_DATA_TREADY;
    logic          GRANT, BUSY, LEN_ERR;

    rdmx_xmit_arb #(.DW(DW), .AW(AW), .UW(UW)) dut (
        .clk(clk), .resetn(resetn),
        .S0_PLEN_TDATA(S0_PLEN_TDATA), .S0_PLEN_TVALID(S0_PLEN_TVALID), .S0_PLEN_TREADY(S0_PLEN_TREADY),
        .S0_ADDR_TDATA(S0_ADDR_TDATA), .S0_ADDR_TUSER(S0_ADDR_TUSER), .S0_ADDR_TVALID(S0_ADDR_TVALID),
        .S0_ADDR_TREADY(S0_ADDR_TREADY),
        .S0_DATA_TDATA(S0_DATA_TDATA), .S0_DATA_TLAST(S0_DATA_TLAST), .S0_DATA_TVALID(S0_DATA_TVALID),
        .S0_DATA_TREADY(S0_DATA_TREADY),
        .S1_PLEN_TDATA(S1_PLEN_TDATA), .S1_PLEN_TVALID(S1_PLEN_TVALID), .S1_PLEN_TREADY(S1_PLEN_TREADY),
        .S1_ADDR_TDATA(S1_ADDR_TDATA), .S1_ADDR_TUSER(S1_ADDR_TUSER), .S1_ADDR_TVALID(S1_ADDR_TVALID),
        .S1_ADDR_TREADY(S1_ADDR_TREADY),
        .S1_DATA_TDATA(S1_DATA_TDATA), .S1_DATA_TLAST(S1_DATA_TLAST), .S1_DATA_TVALID(S1_DATA_TVALID),
        .S1_DATA_TREADY(S1_DATA_TREADY),
        .M_HDR_TDATA(M_HDR_TDATA), .M_HDR_TUSER(M_HDR_TUSER), .M_HDR_TLEN(M_HDR_TLEN),
        .M_HDR_TVALID(M_HDR_TVALID), .M_HDR_TREADY(M_HDR_TREADY),
        .M_DATA_TDATA(M_DATA_TDATA), .M_DATA_TLAST(M_DATA_TLAST), .M_DATA_TVALID(M_DATA_TVALID),
        .M_DATA_TREADY(M_DATA_TREADY),
        .GRANT(GRANT), .BUSY(BUSY), .LEN_ERR(LEN_ERR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Upstream FIFO contents: header entries and a flat stream of data beats per channel.
    typedef struct packed {
        logic [15:0]   plen;
        logic [AW-1:0] addr;
        logic [UW-1:0] user;
        logic [1:0]    dly;   // cycles before ADDR becomes valid at the head
    } pk_t;
    typedef struct packed {
        logic          last;
        logic [DW-1:0] d;
    } bt_t;

    pk_t hq[2][$];
    bt_t dq[2][$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: which packet is in flight and how far along it is.
    int  m_phase;      // 0 = waiting for a schedulable packet, 1 = header offered, 2 = streaming data
    int  m_ch;
    int  m_last;
    int  m_grant;
    int  m_beats;
    int  m_exp;
    bit  m_err;
    int  obs_order[$];
    int  hdr_cyc;

    bit  dv_rand, dr_rand, hr_rand;
    int  hdr_low_left;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [DW-1:0] rand_dw();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic int exp_beats_of(input int plen);
        int e;
        e = (plen + (DW / 8) - 1) / (DW / 8);
        return (e < 1) ? 1 : e;
    endfunction

    function automatic int pick_ch(input logic [1:0] el);
`ifdef RDMX_XMIT_ARB_STRICT_PRIO_EN
        return el[0] ? 0 : 1;
`else
        if (el == 2'b11) return (m_last == 1) ? 0 : 1;
        return el[1] ? 1 : 0;
`endif
    endfunction

    task automatic push_pkt(input int c, input int plen, input logic [AW-1:0] addr,
                            input logic [UW-1:0] user, input int nb, input int dly);
        pk_t p;
        bt_t b;
        p.plen = 16'(plen);
        p.addr = addr;
        p.user = user;
        p.dly  = 2'(dly);
        hq[c].push_back(p);
        for (int i = 0; i < nb; i++) begin
            b.last = (i == nb - 1);
            b.d    = rand_dw();
            dq[c].push_back(b);
        end
    endtask

    task automatic model_reset();
        hq[0].delete(); hq[1].delete();
        dq[0].delete(); dq[1].delete();
        m_phase = 0; m_ch = 0; m_last = 1; m_grant = 0; m_beats = 0; m_exp = 0; m_err = 0;
        obs_order.delete();
    endtask

    task automatic drive();
        logic [1:0]    pv, av, dvl, dl;
        logic [15:0]   pl[2];
        logic [AW-1:0] ad[2];
        logic [UW-1:0] us[2];
        logic [DW-1:0] dd[2];
        pk_t p;
        bt_t b;
        for (int c = 0; c < 2; c++) begin
            pv[c] = 1'b0; av[c] = 1'b0; pl[c] = '0; ad[c] = '0; us[c] = '0;
            dvl[c] = 1'b0; dl[c] = 1'b0; dd[c] = '0;
            if (hq[c].size() > 0) begin
                p = hq[c][0];
                pv[c] = 1'b1; av[c] = (p.dly == 2'd0);
                pl[c] = p.plen; ad[c] = p.addr; us[c] = p.user;
            end
            if (dq[c].size() > 0) begin
                b = dq[c][0];
                dvl[c] = !dv_rand || ($urandom % 4 != 0);
                dl[c] = b.last; dd[c] = b.d;
            end
        end
        S0_PLEN_TVALID = pv[0]; S0_PLEN_TDATA = pl[0];
        S0_ADDR_TVALID = av[0]; S0_ADDR_TDATA = ad[0]; S0_ADDR_TUSER = us[0];
        S0_DATA_TVALID = dvl[0]; S0_DATA_TLAST = dl[0]; S0_DATA_TDATA = dd[0];
        S1_PLEN_TVALID = pv[1]; S1_PLEN_TDATA = pl[1];
        S1_ADDR_TVALID = av[1]; S1_ADDR_TDATA = ad[1]; S1_ADDR_TUSER = us[1];
        S1_DATA_TVALID = dvl[1]; S1_DATA_TLAST = dl[1]; S1_DATA_TDATA = dd[1];
        M_HDR_TREADY  = (hdr_low_left > 0) ? 1'b0 : (!hr_rand || ($urandom % 2 == 0));
        M_DATA_TREADY = !dr_rand || ($urandom % 2 == 0);
    endtask

    // Compare one cycle of DUT outputs against the model, then advance the model
    // by whatever handshakes happen on the coming clock edge.
    task automatic check_cycle();
        logic [1:0] el;
        logic       dvv;
        logic [3:0] pops_exp;
        pk_t        p;
        bt_t        b;
        el = {S1_PLEN_TVALID & S1_ADDR_TVALID, S0_PLEN_TVALID & S0_ADDR_TVALID};
        if (M_HDR_TVALID) hdr_cyc++;
        case (m_phase)
            0: begin
                chk("idle_busy", BUSY, 0);
                chk("idle_hdr_vld", M_HDR_TVALID, 0);
                chk("idle_data_vld", M_DATA_TVALID, 0);
                chk("idle_readies", {S1_PLEN_TREADY, S1_ADDR_TREADY, S1_DATA_TREADY,
                                     S0_PLEN_TREADY, S0_ADDR_TREADY, S0_DATA_TREADY}, 0);
                chk("idle_grant", GRANT, m_grant);
                chk("idle_len_err", LEN_ERR, m_err);
                if (el != 2'b00) begin
                    m_ch = pick_ch(el);
                    m_grant = m_ch;
                    m_phase = 1;
                end
            end
            1: begin
                p = hq[m_ch][0];
                chk("hdr_busy", BUSY, 1);
                chk("hdr_vld", M_HDR_TVALID, 1);
                chk("hdr_addr", M_HDR_TDATA, p.addr);
                chk("hdr_user", M_HDR_TUSER, p.user);
                chk("hdr_len", M_HDR_TLEN, p.plen);
                chk("hdr_grant", GRANT, m_ch);
                chk("hdr_data_vld", M_DATA_TVALID, 0);
                chk("hdr_data_rdy", {S1_DATA_TREADY, S0_DATA_TREADY}, 0);
                pops_exp = !M_HDR_TREADY ? 4'b0000 : ((m_ch == 1) ? 4'b1100 : 4'b0011);
                chk("hdr_pops", {S1_PLEN_TREADY, S1_ADDR_TREADY, S0_PLEN_TREADY, S0_ADDR_TREADY}, pops_exp);
                if (M_HDR_TREADY) begin
                    obs_order.push_back(int'(GRANT));
                    m_exp = exp_beats_of(int'(p.plen));
                    void'(hq[m_ch].pop_front());
                    m_beats = 0;
                    m_phase = 2;
                end else if (hdr_low_left > 0) begin
                    hdr_low_left--;
                end
            end
            default: begin
                dvv = (m_ch == 1) ? S1_DATA_TVALID : S0_DATA_TVALID;
                chk("data_busy", BUSY, 1);
                chk("data_hdr_vld", M_HDR_TVALID, 0);
                chk("data_grant", GRANT, m_ch);
                chk("data_vld", M_DATA_TVALID, dvv);
                chk("data_pops", {S1_PLEN_TREADY, S1_ADDR_TREADY, S0_PLEN_TREADY, S0_ADDR_TREADY}, 0);
                chk("data_rdy", {S1_DATA_TREADY, S0_DATA_TREADY},
                    (m_ch == 1) ? {M_DATA_TREADY, 1'b0} : {1'b0, M_DATA_TREADY});
                if (dvv) begin
                    b = dq[m_ch][0];
                    chk("data_tdata", M_DATA_TDATA, b.d);
                    chk("data_tlast", M_DATA_TLAST, b.last);
                    if (M_DATA_TREADY) begin
                        void'(dq[m_ch].pop_front());
                        m_beats++;
                        if (b.last) begin
                            if (m_beats != m_exp) m_err = 1'b1;
                            m_last = m_ch;
                            m_phase = 0;
                        end
                    end
                end
            end
        endcase
        for (int c = 0; c < 2; c++) begin
            if (hq[c].size() > 0 && hq[c][0].dly != 2'd0) begin
                p = hq[c][0];
                p.dly = p.dly - 2'd1;
                hq[c][0] = p;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
        #1;
        check_cycle();
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        int n;
        n = 0;
        while ((hq[0].size() > 0 || hq[1].size() > 0 || m_phase != 0) && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_done_in_budget"}, (n < budget), 1);
        step();   // one idle cycle so the sticky flag and grant get checked after the last packet
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        model_reset();
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic chk_order(input string tag, input int expo[$]);
        chk({tag, "_count"}, obs_order.size(), expo.size());
        for (int i = 0; i < expo.size() && i < obs_order.size(); i++)
            chk($sformatf("%s_%0d", tag, i), obs_order[i], expo[i]);
    endtask

    initial begin
        int expo[$];
        int pushed;
        int n;
        int plen, nb, e;

        dv_rand = 0; dr_rand = 0; hr_rand = 0; hdr_low_left = 0; hdr_cyc = 0;
        resetn = 1'b0;
        model_reset();
        drive();
        #3;
        chk("rst_busy", BUSY, 0);
        chk("rst_grant", GRANT, 0);
        chk("rst_len_err", LEN_ERR, 0);
        chk("rst_valids", {M_HDR_TVALID, M_DATA_TVALID}, 0);
        chk("rst_readies", {S1_PLEN_TREADY, S1_ADDR_TREADY, S1_DATA_TREADY,
                            S0_PLEN_TREADY, S0_ADDR_TREADY, S0_DATA_TREADY}, 0);
        apply_reset();

        // Single ch0 packet: 200 bytes -> 4 beats, header one cycle after eligibility.
        push_pkt(0, 200, 64'h1000, 40'h5, 4, 0);
        run_until_idle("ch0_single", 50);
        chk_order("ch0_single_order", '{0});

        // Ch1 data stream valid but never granted while a ch0 packet drains under toggling ready.
        obs_order.delete();
        dr_rand = 1;
        push_pkt(0, 256, 64'h2000, 40'h6, 4, 0);
        for (int i = 0; i < 3; i++) dq[1].push_back({1'b0, rand_dw()});
        run_until_idle("ch1_blocked", 100);
        chk_order("ch1_blocked_order", '{0});
        dr_rand = 0;

        // Three packets queued on each channel from reset.
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            push_pkt(0, 64 * (i + 1), 64'(32'h100 + i), 40'(i), i + 1, 0);
            push_pkt(1, 64 * (i + 2), 64'(32'h200 + i), 40'(i + 8), i + 2, 0);
        end
        run_until_idle("rr3", 200);
`ifdef RDMX_XMIT_ARB_STRICT_PRIO_EN
        expo = '{0, 0, 0, 1, 1, 1};
`else
        expo = '{0, 1, 0, 1, 0, 1};
`endif
        chk_order("rr3_order", expo);

        // Header held for five cycles of M_HDR_TREADY low.
        hdr_cyc = 0;
        hdr_low_left = 5;
        push_pkt(0, 64, 64'hABCD_0000, 40'h77, 1, 0);
        run_until_idle("hdr_hold", 50);
        chk("hdr_hold_cycles", hdr_cyc, 6);

        // Ch1 declares 64 bytes (1 beat) but sends 2; the next clean packet leaves the flag set.
        push_pkt(1, 64, 64'h3000, 40'h9, 2, 0);
        push_pkt(1, 64, 64'h3040, 40'hA, 1, 0);
        run_until_idle("len_err", 50);
        chk("len_err_sticky", LEN_ERR, 1);

        // Reset on beat 2 of a 4-beat ch0 packet.
        push_pkt(0, 256, 64'h4000, 40'h1, 4, 0);
        n = 0;
        while (!(m_phase == 2 && m_beats == 1) && n < 20) begin
            step();
            n++;
        end
        chk("mid_rst_reached", (n < 20), 1);
        resetn = 1'b0;
        #1;
        chk("mid_rst_valids", {M_HDR_TVALID, M_DATA_TVALID}, 0);
        chk("mid_rst_readies", {S1_PLEN_TREADY, S1_ADDR_TREADY, S1_DATA_TREADY,
                                S0_PLEN_TREADY, S0_ADDR_TREADY, S0_DATA_TREADY}, 0);
        chk("mid_rst_busy", BUSY, 0);
        chk("mid_rst_len_err", LEN_ERR, 0);
        apply_reset();
        push_pkt(1, 64, 64'h5100, 40'h2, 1, 0);
        push_pkt(0, 64, 64'h5000, 40'h3, 1, 0);
        run_until_idle("post_rst", 50);
        chk_order("post_rst_order", '{0, 1});

        // Randomized traffic: random lengths, occasional beat-count errors, late addresses and throttling.
        dv_rand = 1; dr_rand = 1; hr_rand = 1;
        pushed = 0;
        while (pushed < 60) begin
            if ($urandom % 5 == 0) begin
                plen = $urandom_range(0, 1100);
                e = exp_beats_of(plen);
                nb = e;
                if ($urandom % 8 == 0) nb = ($urandom % 2 == 0 || e == 1) ? e + 1 : e - 1;
                push_pkt($urandom % 2, plen, {$urandom, $urandom}, {8'($urandom), $urandom},
                         nb, $urandom_range(0, 3));
                pushed++;
            end
            step();
        end
        run_until_idle("random", 20000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
